// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Purely declarative: no logic, no latency, no flow control.
package arbitro_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } estado_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arbitro_rr_4_prioridad.sv
// Rotating priority search: first set bit of req scanning upward from inicio, wrapping.
// Purely combinational, zero latency; no flow control of its own.
module prioridad_rr
    import arbitro_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] inicio,
    output logic             hay,
    output logic [SEL_W-1:0] gan
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester overwrites the result.
    always_comb begin
        hay = 1'b0;
        gan = inicio;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = inicio + SEL_W'(k);
            if (req[idx]) begin
                hay = 1'b1;
                gan = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_4.sv
// Round-robin arbiter for a shared 4:1 mux / 1:4 demux with a per-owner burst quota.
// One cycle from req to registered grant/S/valid; owner keeps the path until it drops or hits MAX_CICLOS.
module arbitro_rr_4
    import arbitro_pkg::*;
#(
    parameter int MAX_CICLOS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] S,
    output logic             valid
);

    localparam int CW = (MAX_CICLOS < 2) ? 1 : $clog2(MAX_CICLOS + 1);

    estado_t          state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ult_q, ult_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [SEL_W-1:0] inicio;
    logic             hay;
    logic [SEL_W-1:0] gan;
    logic             conserva;

    // While granted, ult equals the owner, so one search from ult+1 covers both idle and release.
    assign inicio = ult_q + SEL_W'(1);

    prioridad_rr u_prioridad (
        .req    (req),
        .inicio (inicio),
        .hay    (hay),
        .gan    (gan)
    );

    assign conserva = (state_q == GRANT) && req[s_q] && (cnt_q < CW'(MAX_CICLOS - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        s_d     = s_q;
        valid_d = valid_q;
        ult_d   = ult_q;
        cnt_d   = cnt_q;
        if (conserva) begin
            cnt_d = cnt_q + CW'(1);
        end else if (hay) begin
            state_d = GRANT;
            grant_d = onehot(gan);
            s_d     = gan;
            valid_d = 1'b1;
            ult_d   = gan;
            cnt_d   = '0;
        end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
            ult_q   <= SEL_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            s_q     <= s_d;
            valid_q <= valid_d;
            ult_q   <= ult_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant = grant_q;
    assign S     = s_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_arbitro_rr_4.sv
// Bench for arbitro_rr_4: directed scenarios plus random traffic on a quota-4 and a quota-1 instance.
module tb_arbitro_rr_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a = '0, req_b = '0;
    logic [3:0] grant_a, grant_b;
    logic [1:0] s_a, s_b;
    logic       valid_a, valid_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    arbitro_rr_4 #(.MAX_CICLOS(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .grant(grant_a), .S(s_a), .valid(valid_a)
    );

    arbitro_rr_4 #(.MAX_CICLOS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .grant(grant_b), .S(s_b), .valid(valid_b)
    );

    // Reference: who owns the path, how many cycles it has held it, who owned last.
    int m_owner [2];
    int m_held  [2];
    int m_last  [2];
    int m_sel   [2];
    int m_quota [2] = '{4, 1};

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_held[d]  = 0;
            m_last[d]  = 3;
            m_sel[d]   = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [3:0] r);
        int w;
        if (m_owner[d] >= 0 && r[m_owner[d]] && m_held[d] < m_quota[d]) begin
            m_held[d]++;
        end else begin
            w = -1;
            for (int k = 1; k <= 4 && w < 0; k++)
                if (r[(m_last[d] + k) % 4]) w = (m_last[d] + k) % 4;
            m_owner[d] = w;
            if (w >= 0) begin
                m_held[d] = 1;
                m_last[d] = w;
                m_sel[d]  = w;
            end
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] g, eg;
        logic [1:0] s;
        logic       v;
        for (int d = 0; d < 2; d++) begin
            g  = d ? grant_b : grant_a;
            s  = d ? s_b : s_a;
            v  = d ? valid_b : valid_a;
            eg = (m_owner[d] < 0) ? 4'b0000 : 4'b0001 << m_owner[d];
            check({tag, d ? "/q1 grant" : "/q4 grant"}, g, eg);
            check({tag, d ? "/q1 S" : "/q4 S"}, {2'b00, s}, 4'(m_sel[d]));
            check({tag, d ? "/q1 valid" : "/q4 valid"}, {3'b000, v}, {3'b000, m_owner[d] >= 0});
            check({tag, " onehot"}, {3'b000, $countones(g) <= 1}, 4'b0001);
            check({tag, " grant[S]"}, {3'b000, !v || g[s]}, 4'b0001);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] r0, input logic [3:0] r1);
        req_a = r0;
        req_b = r1;
        @(posedge clk);
        model_step(0, r0);
        model_step(1, r1);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // 1: single requester renews its own grant every quota
        step("t1", 4'b0100, 4'b0000);
        check("t1 first grant", grant_a, 4'b0100);
        check("t1 first S", {2'b00, s_a}, 4'b0010);
        repeat (9) step("t1", 4'b0100, 4'b0000);

        // 2: everybody requesting, full rotation
        repeat (20) step("t2", 4'b1111, 4'b1111);
        step("t2 idle", 4'b0000, 4'b0000);

        // 3: early release then idle, S keeps the last owner
        repeat (2) step("t3", 4'b0010, 4'b0010);
        step("t3 idle", 4'b0000, 4'b0000);
        check("t3 S held", {2'b00, s_a}, 4'b0001);
        check("t3 valid low", {3'b000, valid_a}, 4'b0000);

        // 4: owner drops as another raises -> handover without bubble
        repeat (2) step("t4", 4'b0001, 4'b0001);
        step("t4 hand", 4'b1000, 4'b1000);
        check("t4 handover", grant_a, 4'b1000);

        // 5: asynchronous reset mid-burst
        step("t5", 4'b1000, 4'b1000);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t5 async grant", grant_a, 4'b0000);
        check("t5 async S", {2'b00, s_a}, 4'b0000);
        check("t5 async valid", {3'b000, valid_a}, 4'b0000);
        #1 rst_n = 1'b1;
        step("t5 rel", 4'b1001, 4'b1001);
        check("t5 src0 first", grant_a, 4'b0001);

        // 6: quota-1 instance alternates on 0101
        repeat (8) step("t6", 4'b0101, 4'b0101);

        // Random traffic, biased toward sticky requests so bursts reach the quota
        begin
            logic [3:0] r0, r1;
            r0 = '0;
            r1 = '0;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 3) == 0) r0 = 4'($urandom);
                if ($urandom_range(0, 3) == 0) r1 = 4'($urandom);
                step("rand", r0, r1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arbitro_rr_4.md
Name: arbitro_rr_4

Overview:
- Round-robin arbiter that shares one mux_4_1 / demux_1_4 pair between four requesters.
- Registered `S` drives both the mux and demux selects; one-hot `grant` tells each requester when it owns the shared path.
- Holds a grant while the owner keeps requesting, up to a burst quota, then rotates to the next requester.
- Sits between the requesting sources and the mux/demux datapath.

Parameters:
- `MAX_CICLOS`, default 4: maximum consecutive cycles one owner may hold the grant (must be ≥1).
- `CW`, default `$clog2(MAX_CICLOS+1)` (min 1): width of the burst counter. Derived; not to be overridden.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  request per source; bit i = source i.
- `grant`  output  4  one-hot grant; all zeros when idle.
- `S`  output  2  mux/demux select = index of the current owner.
- `valid`  output  1  high while a grant is active; used as demux enable.

Behaviour:
- Reset (asynchronous on `rst_n`=0, any time, including mid-burst):
  - `grant`=0000, `S`=00, `valid`=0, state=IDLE, `cnt`=0.
  - Last-owner pointer `ult`=3, so source 0 has top priority first.
- All outputs are registered. No combinational path from `req` to outputs.
- Priority search: first set bit of `req`, scanning from `(ult+1) mod 4` upward with wrap-around.
- IDLE state:
  - `req`=0000: stay in IDLE; outputs unchanged (`S` keeps its last value).
  - Any `req` set: on the next edge go to GRANT. Set `grant`=onehot(w), `S`=w, `valid`=1, `ult`=w, `cnt`=0, where w is the search winner.
  - Latency: `req` sampled at edge k gives `grant` visible after edge k (1 cycle).
- GRANT state, at each edge with owner o:
  - Keep: `req[o]`=1 and `cnt` < `MAX_CICLOS`-1. `cnt` increments; outputs hold.
  - Release: `req[o]`=0, or `cnt`=`MAX_CICLOS`-1. Re-arbitrate on the same edge with the search starting from o+1.
  - Release with a winner w: grant w directly, with no idle bubble. `cnt`=0, `ult`=w.
  - Winner may be o again if o is the only requester still requesting after quota expiry. Grant is then renewed with `cnt`=0.
  - Release with no requester: go to IDLE; `grant`=0000, `valid`=0, `S` holds.
- Simultaneous events:
  - Owner drops `req` in the same cycle another source raises it: the handover happens on that edge.
  - Requests from non-owners never preempt before the quota or the owner's drop.
- Invariants:
  - `grant` is always 0000 or one-hot.
  - `grant[S]`=1 whenever `valid`=1.
  - `valid`=1 exactly when `grant`≠0.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,… and each owner holds for `MAX_CICLOS` cycles.
- `MAX_CICLOS`=1: the grant rotates every cycle when the others request.

Decomposition:
- Package `arbitro_pkg` contains:
  - `N_REQ`=4, `SEL_W`=2.
  - State enum `estado_t` {IDLE, GRANT}.
  - Function `onehot(idx)`.
- Sub-module `prioridad_rr` (combinational):
  - Inputs: `req[3:0]`, `inicio[1:0]`.
  - Outputs: `hay`, `gan[1:0]`.
  - Instantiated once in `arbitro_rr_4`.

Test Plan (`MAX_CICLOS`=4 unless stated):
1. Reset then single request:
   - Stimulus: `rst_n` low 2 cycles; `req`=0100 held.
   - Response: one edge later `grant`=0100, `S`=10, `valid`=1. Grant renews every 4 cycles while `req` stays 0100.
2. All request continuously, `req`=1111:
   - Grant sequence 0001,0010,0100,1000,0001, each held 4 cycles.
   - `S` follows 00,01,10,11.
   - No cycle with `valid`=0.
3. Early release and idle:
   - Stimulus: `req`=0010 for 2 cycles, then 0000.
   - Response: `grant`=0010 for 2 cycles, then 0000 and `valid`=0; `S` stays 01.
4. Handover on the same edge:
   - Stimulus: owner 0 drops `req`[0] in the cycle `req`[3] rises (`req` 0001→1000).
   - Response: next edge `grant`=1000, `S`=11, no bubble.
5. Asynchronous reset mid-burst:
   - Stimulus: `rst_n`=0 between edges while `grant`=1000.
   - Response: outputs immediately `grant`=0000, `S`=00, `valid`=0.
   - After release with `req`=1001: source 0 wins first.
6. `MAX_CICLOS`=1, `req`=0101:
   - Grant alternates 0001,0100 every cycle.
   - Bench checks the invariants (one-hot `grant`, `grant[S]`=1 when `valid`) on every cycle.
